// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver timed by a 16x oversampling strobe, with a one-entry valid/ready holding register.
// Latency: byte presented 1 clk after the stop-bit centre tick; frame_error_p/overrun_p pulse on that same clock.
// Backpressure: a single byte is held until accepted; a byte completing while the holder is full is dropped (overrun_p).
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk210_p,
    input  logic                 reset_p,
    input  logic                 baud_16_x_p,
    input  logic                 rx_serial_p,
    output logic [DATA_BITS-1:0] rx_data_p,
    output logic                 rx_valid_p,
    input  logic                 rx_ready_p,
    output logic                 frame_error_p,
    output logic                 overrun_p,
    output logic                 rx_busy_p
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    state_t                 state;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   byte_ok;
    logic                   accept;

    assign rxs = sync_q[SYNC_STAGES-1];

    // A clean byte is complete on the stop-centre tick when the stop bit reads high.
    assign byte_ok = baud_16_x_p && (state == STOP) && (tick_cnt == LAST_TICK) && rxs;
    assign accept  = rx_valid_p && rx_ready_p;

    // Pin synchroniser; runs every clock and resets to the idle-high level.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial_p};
        end
    end

    // Frame FSM: advances only on oversampling ticks, single centre sample per bit.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_q       <= '0;
            frame_error_p <= 1'b0;
            rx_busy_p     <= 1'b0;
        end else begin
            frame_error_p <= 1'b0;
            if (baud_16_x_p) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state     <= START;
                            tick_cnt  <= '0;
                            rx_busy_p <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_TICK) begin
                            tick_cnt <= '0;
                            if (!rxs) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                // Line went back high before mid-bit: treat as a glitch.
                                state     <= IDLE;
                                rx_busy_p <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            shift_q  <= {rxs, shift_q[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                state   <= STOP;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            // Return at stop centre so a back-to-back start edge is caught.
                            state         <= IDLE;
                            tick_cnt      <= '0;
                            rx_busy_p     <= 1'b0;
                            frame_error_p <= !rxs;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        rx_busy_p <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register: load when empty or being drained this clock, else drop and flag overrun.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            rx_data_p  <= '0;
            rx_valid_p <= 1'b0;
            overrun_p  <= 1'b0;
        end else begin
            overrun_p <= 1'b0;
            if (byte_ok && (!rx_valid_p || accept)) begin
                rx_data_p  <= shift_q;
                rx_valid_p <= 1'b1;
            end else if (byte_ok) begin
                overrun_p <= 1'b1;
            end else if (accept) begin
                rx_valid_p <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: table of single frames plus hand-written corner sequences.
// Frames are driven tick-aligned; every bit is held 16 ticks so each centre sample is unambiguous.
// Results are compared against hand-computed constants.
module tb_uart_rx_oversampled;

    logic       clk210_p = 1'b0;
    logic       reset_p;
    logic       baud_16_x_p;
    logic       rx_serial_p;
    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic       rx_ready_p;
    logic       frame_error_p;
    logic       overrun_p;
    logic       rx_busy_p;

    int checks   = 0;
    int failures = 0;
    int div      = 58;
    int tick_ph  = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;

    typedef struct {
        logic       pre_vld;
        logic       pre_busy;
        logic       vld;
        logic [7:0] dat;
        logic       fe;
        logic       ov;
        logic       busy;
        logic       vld_n;
        logic       fe_n;
        logic       ov_n;
    } res_t;

    typedef struct {
        int         tick_div;
        logic [7:0] dat;
        logic       stop_bit;
        logic       exp_vld;
        logic [7:0] exp_dat;
        logic       exp_fe;
    } vec_t;

    uart_rx_oversampled #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk210_p     (clk210_p),
        .reset_p      (reset_p),
        .baud_16_x_p  (baud_16_x_p),
        .rx_serial_p  (rx_serial_p),
        .rx_data_p    (rx_data_p),
        .rx_valid_p   (rx_valid_p),
        .rx_ready_p   (rx_ready_p),
        .frame_error_p(frame_error_p),
        .overrun_p    (overrun_p),
        .rx_busy_p    (rx_busy_p)
    );

    always #5 clk210_p = ~clk210_p;

    // Tick strobe: exactly one clock in every div, changed on the falling edge.
    initial begin
        baud_16_x_p = 1'b0;
        forever begin
            @(negedge clk210_p);
            tick_ph++;
            if (tick_ph >= div) tick_ph = 0;
            baud_16_x_p = (tick_ph == 0);
        end
    end

    // Count flag pulses so spurious ones anywhere in the run are caught.
    always @(negedge clk210_p) begin
        if (frame_error_p) fe_cnt++;
        if (overrun_p) ov_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk210_p); while (baud_16_x_p !== 1'b1);
    endtask

    // Drives one 8N1 frame; samples outputs around the stop-centre tick (16*9+9 ticks after the start edge).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ready_pulse,
                              output res_t r);
        wait_tick();
        #1 rx_serial_p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) wait_tick();
            #1 rx_serial_p = b[i];
        end
        repeat (16) wait_tick();
        #1 rx_serial_p = stop_bit;
        repeat (8) wait_tick();
        #1;
        r.pre_vld  = rx_valid_p;
        r.pre_busy = rx_busy_p;
        if (ready_pulse) begin
            repeat (div - 1) @(posedge clk210_p);
            #1 rx_ready_p = 1'b1;
        end
        wait_tick();
        #1;
        r.vld  = rx_valid_p;
        r.dat  = rx_data_p;
        r.fe   = frame_error_p;
        r.ov   = overrun_p;
        r.busy = rx_busy_p;
        rx_serial_p = 1'b1;
        if (ready_pulse) rx_ready_p = 1'b0;
        @(posedge clk210_p);
        #1;
        r.vld_n = rx_valid_p;
        r.fe_n  = frame_error_p;
        r.ov_n  = overrun_p;
        repeat (7) wait_tick();
    endtask

    task automatic drain();
        @(posedge clk210_p);
        #1 rx_ready_p = 1'b1;
        @(posedge clk210_p);
        #1 chk("drain_vld", rx_valid_p, 1'b0);
        rx_ready_p = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        res_t r;

        vecs[0] = '{58, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{6,  8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{6,  8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{6,  8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{6,  8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

        reset_p     = 1'b1;
        rx_serial_p = 1'b1;
        rx_ready_p  = 1'b1;
        repeat (3) @(posedge clk210_p);
        #1;
        chk("rst_vld",  rx_valid_p,    1'b0);
        chk("rst_dat",  rx_data_p,     8'h00);
        chk("rst_busy", rx_busy_p,     1'b0);
        chk("rst_fe",   frame_error_p, 1'b0);
        chk("rst_ov",   overrun_p,     1'b0);
        reset_p = 1'b0;
        repeat (2) wait_tick();

        // Single frames with the consumer always ready.
        for (int v = 0; v < 5; v++) begin
            div = vecs[v].tick_div;
            send_frame(vecs[v].dat, vecs[v].stop_bit, 1'b0, r);
            chk($sformatf("v%0d_pre_vld", v),  r.pre_vld,  1'b0);
            chk($sformatf("v%0d_pre_busy", v), r.pre_busy, 1'b1);
            chk($sformatf("v%0d_vld", v),      r.vld,      vecs[v].exp_vld);
            if (vecs[v].exp_vld) chk($sformatf("v%0d_dat", v), r.dat, vecs[v].exp_dat);
            chk($sformatf("v%0d_fe", v),       r.fe,       vecs[v].exp_fe);
            chk($sformatf("v%0d_fe_n", v),     r.fe_n,     1'b0);
            chk($sformatf("v%0d_ov", v),       r.ov,       1'b0);
            chk($sformatf("v%0d_busy", v),     r.busy,     1'b0);
            chk($sformatf("v%0d_vld_n", v),    r.vld_n,    1'b0);
        end
        chk("fe_pulses_table", fe_cnt, 1);

        // Start glitch of 4 ticks: rejected at the mid-bit sample.
        div = 6;
        wait_tick();
        #1 rx_serial_p = 1'b0;
        repeat (4) wait_tick();
        #1 rx_serial_p = 1'b1;
        chk("glitch_busy_start", rx_busy_p, 1'b1);
        repeat (4) wait_tick();
        #1 chk("glitch_busy_t7", rx_busy_p, 1'b1);
        wait_tick();
        #1 chk("glitch_busy_idle", rx_busy_p, 1'b0);
        chk("glitch_vld", rx_valid_p, 1'b0);
        repeat (10) wait_tick();
        chk("glitch_fe_cnt", fe_cnt, 1);

        // Overrun: consumer stalled across two frames.
        rx_ready_p = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, r);
        chk("ovr_first_vld", r.vld, 1'b1);
        chk("ovr_first_dat", r.dat, 8'h11);
        chk("ovr_first_held", r.vld_n, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, r);
        chk("ovr_pre_vld", r.pre_vld, 1'b1);
        chk("ovr_dat_kept", r.dat, 8'h11);
        chk("ovr_pulse", r.ov, 1'b1);
        chk("ovr_pulse_end", r.ov_n, 1'b0);
        chk("ovr_fe", r.fe, 1'b0);
        drain();
        chk("ovr_count", ov_cnt, 1);

        // Accept on exactly the completion clock of the second byte.
        send_frame(8'h11, 1'b1, 1'b0, r);
        chk("acc_first_dat", r.dat, 8'h11);
        send_frame(8'h22, 1'b1, 1'b1, r);
        chk("acc_dat", r.dat, 8'h22);
        chk("acc_vld", r.vld, 1'b1);
        chk("acc_ov", r.ov, 1'b0);
        chk("acc_vld_n", r.vld_n, 1'b1);
        drain();
        chk("acc_ov_count", ov_cnt, 1);

        // Reset mid-DATA with a byte held; then a clean frame.
        send_frame(8'h33, 1'b1, 1'b0, r);
        chk("rst6_held", r.vld_n, 1'b1);
        wait_tick();
        #1 rx_serial_p = 1'b0;
        repeat (16) wait_tick();
        #1 rx_serial_p = 1'b1;
        repeat (52) wait_tick();
        #1 chk("rst6_busy_before", rx_busy_p, 1'b1);
        reset_p = 1'b1;
        @(posedge clk210_p);
        #1;
        chk("rst6_vld",  rx_valid_p,    1'b0);
        chk("rst6_dat",  rx_data_p,     8'h00);
        chk("rst6_busy", rx_busy_p,     1'b0);
        chk("rst6_fe",   frame_error_p, 1'b0);
        chk("rst6_ov",   overrun_p,     1'b0);
        reset_p    = 1'b0;
        rx_ready_p = 1'b1;
        repeat (20) wait_tick();
        send_frame(8'h5A, 1'b1, 1'b0, r);
        chk("rst6_next_vld", r.vld, 1'b1);
        chk("rst6_next_dat", r.dat, 8'h5A);
        chk("rst6_next_fe",  r.fe,  1'b0);
        chk("final_fe_count", fe_cnt, 1);
        chk("final_ov_count", ov_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
